// File: rtl/mips_regfile_onehot_if.sv
// Register-file bus: one-hot write port, two read ports and debug status.
// master = control/decoder side, slave = register file.
interface mips_regfile_onehot_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             we;
  logic [31:0]      wsel;
  logic [WIDTH-1:0] wd;
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             onehot_err;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output we, wsel, wd, ra1, ra2,
    input  rd1, rd2, onehot_err, wr_cnt
  );

  modport slave (
    input  we, wsel, wd, ra1, ra2,
    output rd1, rd2, onehot_err, wr_cnt
  );
endinterface

// File: rtl/mips_regfile_onehot.sv
// 32x32 MIPS register file, one-hot write select, $0 hardwired to zero.
// Reads are combinational (0 cycles), writes land on the edge; no backpressure.
module mips_regfile_onehot #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_regfile_onehot_if.slave    bus
);

  logic [WIDTH-1:0] regs [32];
  logic [CNT_W-1:0] wr_cnt_q;
  logic             onehot_err_q;
  logic             sel_onehot;
  logic             legal;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  // x & (x-1) clears the lowest set bit; zero result with nonzero x means one-hot
  assign sel_onehot = (bus.wsel != 32'd0) && ((bus.wsel & (bus.wsel - 32'd1)) == 32'd0);
  assign legal      = bus.we && sel_onehot;

  // X on we/wsel leaves legal unknown, so the if falls through to the error path
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wr_cnt_q     <= '0;
      onehot_err_q <= 1'b0;
    end else if (legal) begin
      for (int i = 1; i < 32; i++) begin
        if (bus.wsel[i]) begin
          regs[i] <= bus.wd;
        end
      end
      wr_cnt_q     <= wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      onehot_err_q <= 1'b0;
    end else if (!bus.we) begin
      onehot_err_q <= 1'b0;
    end else begin
      onehot_err_q <= 1'b1;
    end
  end

  always_comb begin
    rd1_c = '0;
    if (bus.ra1 != 5'd0) begin
      rd1_c = regs[bus.ra1];
      if ((BYPASS != 0) && legal && bus.wsel[bus.ra1]) begin
        rd1_c = bus.wd;
      end
    end
  end

  always_comb begin
    rd2_c = '0;
    if (bus.ra2 != 5'd0) begin
      rd2_c = regs[bus.ra2];
      if ((BYPASS != 0) && legal && bus.wsel[bus.ra2]) begin
        rd2_c = bus.wd;
      end
    end
  end

  assign bus.rd1        = rd1_c;
  assign bus.rd2        = rd2_c;
  assign bus.onehot_err = onehot_err_q;
  assign bus.wr_cnt     = wr_cnt_q;

endmodule
